// File: rtl/satadd_pkg.sv
// Shared types and constants for the saturating-adder BIST slice.
package satadd_pkg;

    localparam int WIDTH = 12;

    localparam logic [1:0] MODE_UWRAP = 2'd0;
    localparam logic [1:0] MODE_USAT  = 2'd1;
    localparam logic [1:0] MODE_SWRAP = 2'd2;
    localparam logic [1:0] MODE_SSAT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Galois right-shift mask for x^24+x^23+x^22+x^17+1
    localparam logic [23:0] LFSR_POLY = 24'hE10000;

    function automatic logic [23:0] lfsr_step(input logic [23:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/satadd_model.sv
// Combinational golden model of the 12-bit saturating adder (all four modes).
module satadd_model
    import satadd_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] y_exp
);

    localparam logic [WIDTH-1:0] UMAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] sat_unsigned(input logic [WIDTH:0] sum);
        return sum[WIDTH] ? UMAX : sum[WIDTH-1:0];
    endfunction

    // Overflow only when both operands share a sign the truncated sum lacks
    function automatic logic [WIDTH-1:0] sat_signed(input logic signed [WIDTH-1:0] x,
                                                    input logic signed [WIDTH-1:0] z,
                                                    input logic [WIDTH:0]          sum);
        logic ovf;
        ovf = (x[WIDTH-1] == z[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        if (!ovf)
            return sum[WIDTH-1:0];
        return (x < 0) ? SMIN : SMAX;
    endfunction

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        case (mode)
            MODE_USAT: y_exp = sat_unsigned(sum);
            MODE_SSAT: y_exp = sat_signed($signed(a), $signed(b), sum);
            default:   y_exp = sum[WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/satadd_vecgen.sv
// BIST vector generator/checker around satadd: LFSR operands, golden compare, counters.
// Optional corner-case ROM for the first 8 vectors: define SATADD_VECGEN_CORNER_EN.
module satadd_vecgen
    import satadd_pkg::*;
#(
    parameter int          NUM_VECTORS   = 256,
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [23:0] SEED          = 24'h5A5A5A
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [1:0]       mode_out,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      vec_count,
    output logic [15:0]      err_count,
    output logic [15:0]      fail_vec
);

    localparam logic [23:0] SEED_EFF = (SEED == 24'h0) ? 24'h000001 : SEED;
    localparam logic [15:0] NUM_V    = 16'(NUM_VECTORS);
    localparam logic [7:0]  SETTLE_V = 8'(SETTLE_CYCLES);

`ifdef SATADD_VECGEN_CORNER_EN
    function automatic logic [2*WIDTH+1:0] corner_rom(input logic [2:0] idx);
        case (idx)
            3'd0: return {MODE_USAT,  12'hFFF, 12'h001};
            3'd1: return {MODE_USAT,  12'h800, 12'h800};
            3'd2: return {MODE_SSAT,  12'h7FF, 12'h001};
            3'd3: return {MODE_SSAT,  12'h800, 12'hFFF};
            3'd4: return {MODE_UWRAP, 12'hFFF, 12'h001};
            3'd5: return {MODE_SWRAP, 12'h7FF, 12'h001};
            3'd6: return {MODE_SSAT,  12'h400, 12'h400};
            default: return {MODE_USAT, 12'h000, 12'h000};
        endcase
    endfunction
`endif

    state_t           state;
    logic [23:0]      lfsr;
    logic [7:0]       settle_cnt;
    logic [WIDTH-1:0] exp_q;

    logic [WIDTH-1:0] nxt_a, nxt_b, y_exp_nxt;
    logic [1:0]       nxt_mode;
    logic             rom_vec;
    logic             mismatch;
    logic [15:0]      err_nxt, vec_nxt;

    always_comb begin
        nxt_a    = lfsr[23:12];
        nxt_b    = lfsr[11:0];
        nxt_mode = vec_count[1:0];
        rom_vec  = 1'b0;
`ifdef SATADD_VECGEN_CORNER_EN
        if (vec_count < 16'd8) begin
            rom_vec = 1'b1;
            {nxt_mode, nxt_a, nxt_b} = corner_rom(vec_count[2:0]);
        end
`endif
    end

    satadd_model u_model (
        .a     (nxt_a),
        .b     (nxt_b),
        .mode  (nxt_mode),
        .y_exp (y_exp_nxt)
    );

    always_comb begin
        mismatch = (y_in != exp_q);
        err_nxt  = (mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;
        vec_nxt  = vec_count + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            lfsr       <= SEED_EFF;
            settle_cnt <= 8'd0;
            exp_q      <= '0;
            a_out      <= '0;
            b_out      <= '0;
            mode_out   <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec_count  <= 16'd0;
            err_count  <= 16'd0;
            fail_vec   <= 16'hFFFF;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec_count <= 16'd0;
                        err_count <= 16'd0;
                        fail_vec  <= 16'hFFFF;
                        lfsr      <= SEED_EFF;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        state     <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    a_out      <= nxt_a;
                    b_out      <= nxt_b;
                    mode_out   <= nxt_mode;
                    exp_q      <= y_exp_nxt;
                    settle_cnt <= SETTLE_V;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt <= 8'd1)
                        state <= ST_CHECK;
                    else
                        settle_cnt <= settle_cnt - 8'd1;
                end
                ST_CHECK: begin
                    err_count <= err_nxt;
                    if (mismatch && (fail_vec == 16'hFFFF))
                        fail_vec <= vec_count;
                    vec_count <= vec_nxt;
                    // Corner vectors leave the LFSR parked on the seed
                    if (!rom_vec)
                        lfsr <= lfsr_step(lfsr);
                    if (vec_nxt == NUM_V) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == 16'd0);
                        state <= ST_DONE;
                    end else begin
                        state <= ST_APPLY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_satadd_vecgen.sv
// Bench for satadd_vecgen: model vector table, random model checks, and full BIST runs.
module tb_satadd_vecgen;

    localparam int N   = 256;
    localparam int S   = 4;
    localparam int PER = S + 2;

    typedef struct {
        logic [1:0]  m;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] y;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [11:0] a_out, b_out, y_in;
    logic [1:0]  mode_out;
    logic        busy, done, pass;
    logic [15:0] vec_count, err_count, fail_vec;
    bit          stuck;

    logic [11:0] ma, mb, my;
    logic [1:0]  mm;

    int total = 0;
    int bad   = 0;

    vec_t        tbl[15];
    logic [11:0] ea[N];
    logic [11:0] eb[N];
    logic [1:0]  em[N];

    always #5 clk = ~clk;

    satadd_vecgen #(.NUM_VECTORS(N), .SETTLE_CYCLES(S), .SEED(24'h5A5A5A)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a_out(a_out), .b_out(b_out), .mode_out(mode_out), .y_in(y_in),
        .busy(busy), .done(done), .pass(pass),
        .vec_count(vec_count), .err_count(err_count), .fail_vec(fail_vec)
    );

    satadd_model u_m (.a(ma), .b(mb), .mode(mm), .y_exp(my));

    // Reference adder in plain integer arithmetic
    function automatic logic [11:0] ref_add(input logic [11:0] a, input logic [11:0] b,
                                            input logic [1:0] m);
        int ua, ub, sa, sb, r;
        ua = a; ub = b;
        sa = (ua >= 2048) ? ua - 4096 : ua;
        sb = (ub >= 2048) ? ub - 4096 : ub;
        case (m)
            2'd0: r = (ua + ub) % 4096;
            2'd1: r = (ua + ub > 4095) ? 4095 : ua + ub;
            2'd2: r = sa + sb;
            default: begin
                r = sa + sb;
                if (r > 2047) r = 2047;
                if (r < -2048) r = -2048;
            end
        endcase
        return 12'(r);
    endfunction

    function automatic logic [23:0] lfsr_next(input logic [23:0] x);
        logic [23:0] t;
        t = x >> 1;
        if (x[0]) t = t ^ 24'hE10000;
        return t;
    endfunction

    always_comb y_in = stuck ? 12'h000 : ref_add(a_out, b_out, mode_out);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " pass"}, pass, 0);
        check({tag, " vec_count"}, vec_count, 0);
        check({tag, " err_count"}, err_count, 0);
        check({tag, " fail_vec"}, fail_vec, 32'hFFFF);
        check({tag, " a_out"}, a_out, 0);
        check({tag, " b_out"}, b_out, 0);
        check({tag, " mode_out"}, mode_out, 0);
    endtask

    task automatic build_seq();
        logic [23:0] l;
        l = 24'h5A5A5A;
        for (int k = 0; k < N; k++) begin
`ifdef SATADD_VECGEN_CORNER_EN
            if (k < 8) begin
                em[k] = tbl[k].m; ea[k] = tbl[k].a; eb[k] = tbl[k].b;
                continue;
            end
`endif
            em[k] = 2'(k % 4);
            ea[k] = l[23:12];
            eb[k] = l[11:0];
            l = lfsr_next(l);
        end
    endtask

    task automatic do_run(input string tag, input bit busy_pulse);
        int  c, k, ecnt, efail;
        bit  got_done;
        ecnt = 0; efail = 32'hFFFF;
        for (int i = 0; i < N; i++)
            if (stuck && ref_add(ea[i], eb[i], em[i]) != 12'h000) begin
                ecnt++;
                if (efail == 32'hFFFF) efail = i;
            end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, " busy_after_start"}, busy, 1);
        check({tag, " done_after_start"}, done, 0);
        check({tag, " vec_cleared"}, vec_count, 0);
        got_done = 0; c = 0;
        while (!got_done && c < N * PER + 20) begin
            @(negedge clk);
            c++;
            if (busy_pulse) begin
                start = (c == 100);
                if (c == 102) check({tag, " vec_after_busy_start"}, vec_count, c / PER);
            end
            if (c % PER == 2) begin
                k = (c - 2) / PER;
                if (k < N) check({tag, " operands"}, {mode_out, a_out, b_out}, {em[k], ea[k], eb[k]});
`ifndef SATADD_VECGEN_CORNER_EN
                if (k == 0) check({tag, " first_vec"}, {a_out, b_out}, {12'h5A5, 12'hA5A});
`endif
            end
            if (done) got_done = 1;
        end
        start = 1'b0;
        check({tag, " run_clocks"}, c, N * PER);
        check({tag, " done"}, done, 1);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " vec_count"}, vec_count, N);
        check({tag, " err_count"}, err_count, ecnt);
        check({tag, " fail_vec"}, fail_vec, efail);
        check({tag, " pass"}, pass, (ecnt == 0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // First eight rows double as the corner ROM
        tbl[0]  = '{2'd1, 12'hFFF, 12'h001, 12'hFFF};
        tbl[1]  = '{2'd1, 12'h800, 12'h800, 12'hFFF};
        tbl[2]  = '{2'd3, 12'h7FF, 12'h001, 12'h7FF};
        tbl[3]  = '{2'd3, 12'h800, 12'hFFF, 12'h800};
        tbl[4]  = '{2'd0, 12'hFFF, 12'h001, 12'h000};
        tbl[5]  = '{2'd2, 12'h7FF, 12'h001, 12'h800};
        tbl[6]  = '{2'd3, 12'h400, 12'h400, 12'h7FF};
        tbl[7]  = '{2'd1, 12'h000, 12'h000, 12'h000};
        tbl[8]  = '{2'd0, 12'h123, 12'h456, 12'h579};
        tbl[9]  = '{2'd2, 12'h800, 12'h800, 12'h000};
        tbl[10] = '{2'd3, 12'h7FF, 12'h7FF, 12'h7FF};
        tbl[11] = '{2'd3, 12'hFFF, 12'h001, 12'h000};
        tbl[12] = '{2'd1, 12'hFFE, 12'h001, 12'hFFF};
        tbl[13] = '{2'd3, 12'hA00, 12'h300, 12'hD00};
        tbl[14] = '{2'd3, 12'h800, 12'h800, 12'h800};

        reset = 1'b1; start = 1'b0; stuck = 1'b0;
        ma = '0; mb = '0; mm = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset("idle");

        for (int i = 0; i < 15; i++) begin
            ma = tbl[i].a; mb = tbl[i].b; mm = tbl[i].m;
            #1;
            check($sformatf("model_tbl[%0d]", i), my, tbl[i].y);
        end
        for (int i = 0; i < 300; i++) begin
            ma = 12'($urandom); mb = 12'($urandom); mm = 2'($urandom_range(0, 3));
            #1;
            check("model_rand", my, ref_add(ma, mb, mm));
        end

        build_seq();
        do_run("good", 1'b0);

        stuck = 1'b1;
        do_run("stuck", 1'b0);
        stuck = 1'b0;

        // Abort in the middle of vector 10's settle window
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10 * PER + 3) @(negedge clk);
        check("pre_reset vec_count", vec_count, 10);
        check("pre_reset busy", busy, 1);
        #2 reset = 1'b1;
        #1 check_reset("async_reset");
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check_reset("post_reset");
        do_run("after_reset", 1'b0);

        do_run("busy_start", 1'b1);
        do_run("restart", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
